hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Generates the 2-bit select codes that steer the EX-stage operand mux4 instances, plus the pipeline stall for load-use and multiply/divide hazards, in the 5-stage MIPS32 core. It tracks in-flight register writers internally and compares them against the instruction in ID. It registers the forwarding selects so they arrive in EX together with the instruction. It is the only stall source for PC and IF/ID.

## Interface
- REG_ADDR_W, 5, register-file address width
- MD_LATENCY, 4, cycles the HI/LO multiply/divide unit stays busy after an mult/div enters EX (≥1)

- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  source register numbers of ID instruction
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
- id_dst  in  REG_ADDR_W  destination register of ID instruction
- id_reg_write  in  1  instruction writes id_dst
- id_is_load  in  1  instruction is lw/lh/lb family
- id_is_md  in  1  instruction is mult/multu/div/divu
- id_reads_hilo  in  1  instruction is mfhi/mflo
- ex_flush  in  1  squash ID instruction (taken branch/jump resolved)
- stall  out  1  hold PC and IF/ID; combinational
- ex_fwd_a_sel, ex_fwd_b_sel  out  2  registered mux4 selects for EX operand A (rs) / B (rt)
- md_busy  out  1  HI/LO unit busy counter nonzero

## Operation
- Select codes: 00 = ID/EX register-file value, 01 = WB result, 10 = MEM ALU result, 11 = reserved, never driven.
- Tracker: three entries EX, MEM, WB, each {valid, dst, wr, load}. Every cycle WB←MEM and MEM←EX. EX←ID fields, except on a bubble, where EX.valid←0.
- Bubble into EX when stall=1, ex_flush=1 or id_valid=0.
- Forward match for source s (rs or rt): use_s, s≠0, entry valid, entry wr, entry dst==s.
- Match against EX entry → next sel 10. Otherwise match against MEM entry → next sel 01. Otherwise 00.
- EX entry has priority (newest producer wins).
- Current WB entry is never forwarded. The register file writes in the first half-cycle, so it is ignored.
- Load-use stall: the EX entry is a valid load, and a used, nonzero id_rs or id_rt equals its dst.
- MD stall: md_busy=1, id_valid=1, and (id_is_md or id_reads_hilo).
- stall = id_valid & ~ex_flush & (load-use | MD stall). ex_flush overrides stall.
- MD counter: when an id_is_md instruction enters EX (no bubble), the counter loads MD_LATENCY. Otherwise it decrements while nonzero. Width is clog2(MD_LATENCY+1).
- md_busy = (counter≠0).
- On a bubble, both selects register 00.

## Timing
- Reset: tracker valid bits 0, counter 0, ex_fwd_a_sel=ex_fwd_b_sel=00, md_busy=0. stall evaluates to 0.
- Reset mid-operation discards all tracked writers and any pending MD busy time.
- Selects have 1-cycle latency. They are computed in ID and valid during the cycle the instruction occupies EX.
- stall has zero latency: same cycle as the ID inputs.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, and the dependent instruction receives sel 01.
- MD stall holds until the counter reaches 0. The waiting instruction enters EX on the first cycle md_busy=0.
- Simultaneous load-use and ex_flush: flush wins, no stall, bubble inserted.
- Back-to-back mult: the second waits the full MD_LATENCY.

## Structure
- Shared package mips_pkg holds:
  - FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FWD_RSVD=2'b11
  - REG_ZERO = 0
  - a pipe_writer_t struct {valid, dst, wr, load}
- One sub-module: md_busy_counter (load/decrement counter, busy output). Tracker and compare logic stay in the top module.

## Test plan
- add $3,$1,$2 then sub $4,$3,$5 back-to-back → sub in EX sees ex_fwd_a_sel=10, stall never asserted.
- add $3 then a nop then or $6,$0,$3 → or in EX sees ex_fwd_b_sel=01. A second instruction reading $3 one cycle later sees 00.
- lw $7 then addu $8,$7,$7 → stall=1 for exactly 1 cycle, EX bubble. addu then gets ex_fwd_a_sel=ex_fwd_b_sel=01.
- Writer to $0 followed by a reader of $0 → selects 00. add $9 in MEM and in EX, reader of $9 → 10 (newest).
- mult then mflo immediately, MD_LATENCY=4 → md_busy high 4 cycles, stall high 4 cycles, mflo enters EX on the 5th.
- lw $7 / addu $7-dependent with ex_flush=1 in the stall cycle → stall=0 and bubble. Then assert rst mid-mult → md_busy=0 the next cycle and selects 00.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 core: forwarding select codes, the
// hard-wired zero register, and the in-flight register-writer record used by
// the hazard/forwarding tracker.
package mips_pkg;

  localparam int MIPS_REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_RSVD    = 2'b11;

  localparam logic [MIPS_REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [MIPS_REG_W-1:0] dst;
    logic                  wr;
    logic                  load;
  } pipe_writer_t;

  // True when an in-flight writer produces the register a used source reads.
  // Register zero is hard-wired, so it never has a producer.
  function automatic logic writer_matches(input pipe_writer_t w,
                                          input logic [MIPS_REG_W-1:0] src,
                                          input logic use_src);
    return use_src && (src != REG_ZERO) && w.valid && w.wr && (w.dst == src);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_md_busy_counter.sv
// Busy timer for the HI/LO multiply/divide unit. Reloads to the full latency
// when a mult/div enters EX and counts down to zero otherwise.
module md_busy_counter #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [CNT_W-1:0] count;

  // Reload on a new mult/div, otherwise drain toward zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LATENCY);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage MIPS32 core.
// Tracks the writers in EX/MEM/WB, produces the combinational stall for
// load-use and HI/LO hazards, and registers the EX operand mux selects.
module hazard_forward_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_md,
  input  logic                  id_reads_hilo,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic [1:0]            ex_fwd_a_sel,
  output logic [1:0]            ex_fwd_b_sel,
  output logic                  md_busy
);

  localparam int TRK_EX  = 0;
  localparam int TRK_MEM = 1;
  localparam int TRK_WB  = 2;

  // Index 0 is the newest writer (EX), index 2 the oldest (WB). The WB slot is
  // kept for completeness but never forwarded: the register file writes in the
  // first half-cycle, so ID already reads the fresh value.
  pipe_writer_t trk [3];
  pipe_writer_t ex_next;

  logic [MIPS_REG_W-1:0] rs_n;
  logic [MIPS_REG_W-1:0] rt_n;
  logic                  load_use;
  logic                  md_stall;
  logic                  bubble;
  logic [1:0]            next_a;
  logic [1:0]            next_b;

  assign rs_n = MIPS_REG_W'(id_rs);
  assign rt_n = MIPS_REG_W'(id_rt);

  // Stall decision: a load in EX feeding ID, or a HI/LO access while busy.
  // A flush squashes the ID instruction, so it always suppresses the stall.
  always_comb begin
    load_use = 1'b0;
    md_stall = 1'b0;
    if (trk[TRK_EX].valid && trk[TRK_EX].load) begin
      load_use = (id_use_rs && (rs_n != REG_ZERO) && (rs_n == trk[TRK_EX].dst)) ||
                 (id_use_rt && (rt_n != REG_ZERO) && (rt_n == trk[TRK_EX].dst));
    end
    md_stall = md_busy && id_valid && (id_is_md || id_reads_hilo);
    stall    = id_valid && !ex_flush && (load_use || md_stall);
    bubble   = stall || ex_flush || !id_valid;
  end

  // Forwarding selects for the ID instruction; the newest producer wins.
  always_comb begin
    next_a = FWD_REGFILE;
    next_b = FWD_REGFILE;
    if (writer_matches(trk[TRK_EX], rs_n, id_use_rs)) begin
      next_a = FWD_MEM;
    end else if (writer_matches(trk[TRK_MEM], rs_n, id_use_rs)) begin
      next_a = FWD_WB;
    end
    if (writer_matches(trk[TRK_EX], rt_n, id_use_rt)) begin
      next_b = FWD_MEM;
    end else if (writer_matches(trk[TRK_MEM], rt_n, id_use_rt)) begin
      next_b = FWD_WB;
    end
  end

  // Record the ID instruction as it moves into EX; a bubble leaves EX empty.
  always_comb begin
    ex_next       = '0;
    ex_next.valid = !bubble;
    ex_next.dst   = MIPS_REG_W'(id_dst);
    ex_next.wr    = id_reg_write;
    ex_next.load  = id_is_load;
  end

  // Advance the writer tracker one stage per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        trk[i] <= '0;
      end
    end else begin
      trk[TRK_WB]  <= trk[TRK_MEM];
      trk[TRK_MEM] <= trk[TRK_EX];
      trk[TRK_EX]  <= ex_next;
    end
  end

  // Register the selects so they line up with the instruction in EX.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_fwd_a_sel <= FWD_REGFILE;
      ex_fwd_b_sel <= FWD_REGFILE;
    end else begin
      ex_fwd_a_sel <= next_a;
      ex_fwd_b_sel <= next_b;
    end
  end

  md_busy_counter #(
    .LATENCY (MD_LATENCY)
  ) u_md_busy (
    .clk  (clk),
    .rst  (rst),
    .load (id_is_md && !bubble),
    .busy (md_busy)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline sequences
// from a vector table, then randomized traffic against a reference model.
module tb_hazard_forward_unit;

  localparam int REG_ADDR_W = 5;
  localparam int MD_LATENCY = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0, id_is_md = 1'b0;
  logic       id_reads_hilo = 1'b0, ex_flush = 1'b0;
  logic       stall, md_busy;
  logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;

  int n_vec  = 0;
  int n_fail = 0;

  hazard_forward_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .MD_LATENCY (MD_LATENCY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .id_dst        (id_dst),
    .id_reg_write  (id_reg_write),
    .id_is_load    (id_is_load),
    .id_is_md      (id_is_md),
    .id_reads_hilo (id_reads_hilo),
    .ex_flush      (ex_flush),
    .stall         (stall),
    .ex_fwd_a_sel  (ex_fwd_a_sel),
    .ex_fwd_b_sel  (ex_fwd_b_sel),
    .md_busy       (md_busy)
  );

  always #5 clk = ~clk;

  // One cycle of ID inputs; exp_stall is for that cycle, the rest are the
  // registered values seen after the following rising edge.
  typedef struct {
    logic       rst, valid;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic [4:0] dst;
    logic       wr, load, md, hilo, flush;
    logic       exp_stall;
    logic [1:0] exp_a, exp_b;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    bit valid, wr, load;
    int dst;
  } prod_t;

  vec_t  tbl[$];
  prod_t inflight[$];
  int    md_rem;

  function automatic vec_t mkv(input logic r, input logic v, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs, input logic urt,
                               input logic [4:0] dst, input logic wr, input logic ld,
                               input logic md, input logic hl, input logic fl,
                               input logic st, input logic [1:0] a, input logic [1:0] b,
                               input logic busy);
    vec_t x;
    x.rst = r; x.valid = v; x.rs = rs; x.rt = rt; x.use_rs = urs; x.use_rt = urt;
    x.dst = dst; x.wr = wr; x.load = ld; x.md = md; x.hilo = hl; x.flush = fl;
    x.exp_stall = st; x.exp_a = a; x.exp_b = b; x.exp_busy = busy;
    return x;
  endfunction

  task automatic modelReset();
    prod_t empty;
    empty = '{valid: 0, wr: 0, load: 0, dst: 0};
    inflight.delete();
    inflight.push_back(empty);
    inflight.push_back(empty);
    md_rem = 0;
  endtask

  function automatic logic [1:0] pickSel(input int src, input bit used);
    if (!used || src == 0) return 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (inflight[i].valid && inflight[i].wr && inflight[i].dst == src)
        return (i == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  // Reference model: fills the expected fields, then advances one cycle.
  task automatic modelStep(inout vec_t v);
    bit    lu, mds, st, bub;
    prod_t p;
    lu  = inflight[0].valid && inflight[0].load &&
          ((v.use_rs && v.rs != 0 && int'(v.rs) == inflight[0].dst) ||
           (v.use_rt && v.rt != 0 && int'(v.rt) == inflight[0].dst));
    mds = (md_rem > 0) && v.valid && (v.md || v.hilo);
    st  = v.valid && !v.flush && (lu || mds);
    bub = st || v.flush || !v.valid;
    v.exp_stall = st;
    if (v.rst) begin
      modelReset();
      v.exp_a = 2'b00;
      v.exp_b = 2'b00;
    end else begin
      v.exp_a = bub ? 2'b00 : pickSel(int'(v.rs), v.use_rs);
      v.exp_b = bub ? 2'b00 : pickSel(int'(v.rt), v.use_rt);
      if (!bub && v.md) md_rem = MD_LATENCY;
      else if (md_rem > 0) md_rem--;
      p = '{valid: !bub, wr: v.wr, load: v.load, dst: int'(v.dst)};
      inflight.push_front(p);
      while (inflight.size() > 2) void'(inflight.pop_back());
    end
    v.exp_busy = (md_rem > 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
    id_use_rs = v.use_rs; id_use_rt = v.use_rt; id_dst = v.dst;
    id_reg_write = v.wr; id_is_load = v.load; id_is_md = v.md;
    id_reads_hilo = v.hilo; ex_flush = v.flush;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s vec %0d: got %0b expected %0b", name, idx, act, exp);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge and held for a cycle.
  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v);
    #1;
    checkOutput("stall", idx, {1'b0, stall}, {1'b0, v.exp_stall});
    @(posedge clk);
    #1;
    checkOutput("fwd_a", idx, ex_fwd_a_sel, v.exp_a);
    checkOutput("fwd_b", idx, ex_fwd_b_sel, v.exp_b);
    checkOutput("md_busy", idx, {1'b0, md_busy}, {1'b0, v.exp_busy});
  endtask

  initial begin
    vec_t v;
    //             rst v  rs  rt urs urt dst wr ld md hl fl  st  a      b      busy
    tbl.push_back(mkv(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // reset
    tbl.push_back(mkv(0, 1, 1,  2, 1, 1,  3, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // add $3,$1,$2
    tbl.push_back(mkv(0, 1, 3,  5, 1, 1,  4, 1, 0, 0, 0, 0,  0, 2'b10, 2'b00, 0)); // sub $4,$3,$5
    tbl.push_back(mkv(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // nop
    tbl.push_back(mkv(0, 1, 1,  2, 1, 1,  3, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // add $3
    tbl.push_back(mkv(0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // nop
    tbl.push_back(mkv(0, 1, 0,  3, 1, 1,  6, 1, 0, 0, 0, 0,  0, 2'b00, 2'b01, 0)); // or $6,$0,$3
    tbl.push_back(mkv(0, 1, 3,  3, 1, 1, 10, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // and $10,$3,$3
    tbl.push_back(mkv(0, 1, 1,  0, 1, 0,  7, 1, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // lw $7
    tbl.push_back(mkv(0, 1, 7,  7, 1, 1,  8, 1, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0)); // addu stalls
    tbl.push_back(mkv(0, 1, 7,  7, 1, 1,  8, 1, 0, 0, 0, 0,  0, 2'b01, 2'b01, 0)); // addu proceeds
    tbl.push_back(mkv(0, 1, 1,  2, 1, 1,  0, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // add $0
    tbl.push_back(mkv(0, 1, 0,  0, 1, 1, 11, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // reader of $0
    tbl.push_back(mkv(0, 1, 1,  2, 1, 1,  9, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // add $9
    tbl.push_back(mkv(0, 1, 1,  2, 1, 1,  9, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // add $9
    tbl.push_back(mkv(0, 1, 9,  9, 1, 1, 12, 1, 0, 0, 0, 0,  0, 2'b10, 2'b10, 0)); // reader of $9
    tbl.push_back(mkv(0, 1, 4,  5, 1, 1,  0, 0, 0, 1, 0, 0,  0, 2'b00, 2'b00, 1)); // mult
    for (int i = 0; i < MD_LATENCY; i++)                                          // mflo waits
      tbl.push_back(mkv(0, 1, 0, 0, 0, 0, 13, 1, 0, 0, 1, 0, 1, 2'b00, 2'b00, (i < MD_LATENCY - 1))); 
    tbl.push_back(mkv(0, 1, 0,  0, 0, 0, 13, 1, 0, 0, 1, 0,  0, 2'b00, 2'b00, 0)); // mflo enters
    tbl.push_back(mkv(0, 1, 1,  0, 1, 0,  7, 1, 1, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // lw $7
    tbl.push_back(mkv(0, 1, 7,  7, 1, 1,  8, 1, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0)); // addu + flush
    tbl.push_back(mkv(0, 1, 7,  7, 1, 1,  8, 1, 0, 0, 0, 0,  0, 2'b01, 2'b01, 0)); // next reader
    tbl.push_back(mkv(0, 1, 4,  5, 1, 1,  0, 0, 0, 1, 0, 0,  0, 2'b00, 2'b00, 1)); // mult
    tbl.push_back(mkv(1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // reset mid-mult
    tbl.push_back(mkv(0, 1, 8,  8, 1, 1, 14, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0)); // no stale fwd
    tbl.push_back(mkv(0, 1, 0,  0, 0, 0, 13, 1, 0, 0, 1, 0,  0, 2'b00, 2'b00, 0)); // mflo, idle
    tbl.push_back(mkv(0, 1, 4,  5, 1, 1,  0, 0, 0, 1, 0, 0,  0, 2'b00, 2'b00, 1)); // mult
    for (int i = 0; i < MD_LATENCY; i++)                                          // mult waits
      tbl.push_back(mkv(0, 1, 4, 5, 1, 1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, (i < MD_LATENCY - 1)));
    tbl.push_back(mkv(0, 1, 4,  5, 1, 1,  0, 0, 0, 1, 0, 0,  0, 2'b00, 2'b00, 1)); // mult enters

    $display("[TB] directed table: %0d vectors", tbl.size());
    foreach (tbl[i]) runVector(tbl[i], i);

    $display("[TB] randomized traffic against reference model");
    modelReset();
    v = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    modelStep(v);
    runVector(v, 1000);
    for (int n = 0; n < 600; n++) begin
      v.rst    = ($urandom_range(0, 79) == 0);
      v.valid  = ($urandom_range(0, 7) != 0);
      v.rs     = 5'($urandom_range(0, 7));
      v.rt     = 5'($urandom_range(0, 7));
      v.use_rs = ($urandom_range(0, 4) != 0);
      v.use_rt = ($urandom_range(0, 2) != 0);
      v.dst    = 5'($urandom_range(0, 7));
      v.wr     = ($urandom_range(0, 3) != 0);
      v.load   = ($urandom_range(0, 3) == 0);
      v.md     = ($urandom_range(0, 11) == 0);
      v.hilo   = ($urandom_range(0, 9) == 0);
      v.flush  = ($urandom_range(0, 9) == 0);
      modelStep(v);
      runVector(v, 1001 + n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
